// File: rtl/mixer_pkg.sv
// Shared types and helpers for the time-multiplexed voice mixer.
package mixer_pkg;

  // Mixer control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mix_state_e;

  // Full-precision accumulator width: one extra bit per doubling of voices,
  // so the sum of all voices at full scale can never overflow.
  function automatic int acc_width(input int sample_width, input int num_channels);
    return sample_width + $clog2(num_channels);
  endfunction

  // Auto-gain shift: ceil(log2(count)); 0 and 1 active voices need no shift.
  function automatic int unsigned auto_shift(input int unsigned count);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < count) s = i + 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/mixer_saturate.sv
// Combinational scale-and-reduce stage for the voice mixer.
// Arithmetic right shift of the full-precision sum, then reduction to the
// output width. Macro MIXER_SATURATE_EN selects clamping; without it the
// result wraps (two's-complement truncation) like the legacy summer.
module mixer_saturate #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_W        = 19,
  parameter int SHIFT_W      = 2
) (
  input  logic signed [ACC_W-1:0]        acc_i,
  input  logic        [SHIFT_W-1:0]      shift_i,
  output logic signed [SAMPLE_WIDTH-1:0] sample_o
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] scaled;

`ifdef MIXER_SATURATE_EN
  // Clamp the scaled sum into the signed output range.
  function automatic logic signed [SAMPLE_WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    if (v > MAX_V)      c = MAX_V;
    else if (v < MIN_V) c = MIN_V;
    else                c = v;
    return c[SAMPLE_WIDTH-1:0];
  endfunction
`else
  // Keep the low bits only; overflow wraps around.
  function automatic logic signed [SAMPLE_WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
    return v[SAMPLE_WIDTH-1:0];
  endfunction

  // High bits are intentionally discarded in wrap mode.
  logic unused_hi;
  assign unused_hi = ^{scaled[ACC_W-1:SAMPLE_WIDTH], MAX_V, MIN_V};
`endif

  // Shift then reduce.
  always_comb begin
    scaled   = acc_i >>> shift_i;
    sample_o = reduce(scaled);
  end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: sums up to NUM_CHANNELS signed voices through
// one shared adder (one voice per clock), scales by a fixed or auto-gain
// shift and reduces to SAMPLE_WIDTH. Optional clamping via MIXER_SATURATE_EN
// (see mixer_saturate); default build wraps.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIXED_SHIFT  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] samples,
  input  logic [NUM_CHANNELS-1:0]              channel_en,
  input  logic                                 auto_gain,
  input  logic                                 generate_new_sample,
  input  logic                                 clear_overrun,
  output logic signed [SAMPLE_WIDTH-1:0]       out_sample,
  output logic                                 new_sample_ready,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int ACC_W   = acc_width(SAMPLE_WIDTH, NUM_CHANNELS);
  localparam int IDX_W   = $clog2(NUM_CHANNELS);
  localparam int CNT_W   = IDX_W + 1;
  localparam int SHIFT_W = $clog2(IDX_W + 1);

  mix_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [SAMPLE_WIDTH-1:0] out_q, out_d;
  logic                           rdy_q, rdy_d;
  logic                           busy_q, busy_d;
  logic                           ovr_q, ovr_d;

  // Captured request operands (data only, no reset needed).
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] smp_q;
  logic [NUM_CHANNELS-1:0]              en_q;
  logic                                 ag_q;

  logic                           capture;
  logic signed [SAMPLE_WIDTH-1:0] smp_arr [NUM_CHANNELS];
  logic signed [SAMPLE_WIDTH-1:0] cur;
  logic signed [ACC_W-1:0]        cur_ext;
  logic [SHIFT_W-1:0]             shift;
  logic signed [SAMPLE_WIDTH-1:0] scaled_sample;

  assign capture = (state_q == IDLE) && generate_new_sample;

  // Latch voices, enables and gain mode at request acceptance.
  always_ff @(posedge clk) begin
    if (capture) begin
      smp_q <= samples;
      en_q  <= channel_en;
      ag_q  <= auto_gain;
    end
  end

  // Select the current voice and sign-extend it to accumulator width.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      smp_arr[i] = smp_q[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
    cur     = smp_arr[idx_q];
    cur_ext = {{(ACC_W-SAMPLE_WIDTH){cur[SAMPLE_WIDTH-1]}}, cur};
  end

  // Pick fixed or auto-gain shift from the active voice count.
  always_comb begin
    shift = SHIFT_W'(FIXED_SHIFT);
    if (ag_q) shift = SHIFT_W'(auto_shift(32'(cnt_q)));
  end

  mixer_saturate #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .ACC_W        (ACC_W),
    .SHIFT_W      (SHIFT_W)
  ) u_sat (
    .acc_i    (acc_q),
    .shift_i  (shift),
    .sample_o (scaled_sample)
  );

  // Next-state and datapath control for the mix sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    rdy_d   = 1'b0;
    busy_d  = (state_q == ACCUM);
    ovr_d   = ovr_q;

    if (clear_overrun) ovr_d = 1'b0;
    if (generate_new_sample && (state_q != IDLE)) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (generate_new_sample) begin
          acc_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (en_q[idx_q]) begin
          acc_d = acc_q + cur_ext;
          cnt_d = cnt_q + 1'b1;
        end
        if (idx_q == IDX_W'(NUM_CHANNELS-1)) state_d = OUTPUT;
        else                                 idx_d   = idx_q + 1'b1;
      end
      OUTPUT: begin
        out_d   = scaled_sample;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_sample       = out_q;
  assign new_sample_ready = rdy_q;
  assign busy             = busy_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer (default instance plus a FIXED_SHIFT=0 one).
module tb_voice_mixer;

  logic         clk;
  logic         rst_n;
  logic [127:0] samples;
  logic [7:0]   channel_en;
  logic         auto_gain;
  logic         generate_new_sample;
  logic         clear_overrun;
  logic [15:0]  out_sample;
  logic         new_sample_ready;
  logic         busy;
  logic         overrun;

  logic [127:0] s0_samples;
  logic [7:0]   s0_channel_en;
  logic         s0_auto_gain;
  logic         s0_gen;
  logic         s0_clear;
  logic [15:0]  s0_out;
  logic         s0_rdy;
  logic         s0_busy;
  logic         s0_ovr;

  int n_chk;
  int n_err;

  voice_mixer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .samples             (samples),
    .channel_en          (channel_en),
    .auto_gain           (auto_gain),
    .generate_new_sample (generate_new_sample),
    .clear_overrun       (clear_overrun),
    .out_sample          (out_sample),
    .new_sample_ready    (new_sample_ready),
    .busy                (busy),
    .overrun             (overrun)
  );

  voice_mixer #(.FIXED_SHIFT(0)) dut_s0 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .samples             (s0_samples),
    .channel_en          (s0_channel_en),
    .auto_gain           (s0_auto_gain),
    .generate_new_sample (s0_gen),
    .clear_overrun       (s0_clear),
    .out_sample          (s0_out),
    .new_sample_ready    (s0_rdy),
    .busy                (s0_busy),
    .overrun             (s0_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request at the next edge (edge 0), run edges 1..9, end in the ready cycle.
  task automatic mix(input string tag, input logic [7:0] en, input logic ag,
                     input logic [127:0] smp, input logic [15:0] exp);
    int rc;
    samples = smp; channel_en = en; auto_gain = ag;
    generate_new_sample = 1'b1;
    tick();
    generate_new_sample = 1'b0;
    rc = 0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (new_sample_ready) rc++;
    end
    chk({tag, "_rdy9"}, 32'(new_sample_ready), 32'd1);
    chk({tag, "_out"}, 32'(out_sample), 32'(exp));
    chk({tag, "_npulse"}, rc, 1);
  endtask

  initial begin
    logic [127:0] p;
    int rc;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    samples = '0; channel_en = '0; auto_gain = 1'b0;
    generate_new_sample = 1'b0; clear_overrun = 1'b0;
    s0_samples = '0; s0_channel_en = '0; s0_auto_gain = 1'b0;
    s0_gen = 1'b0; s0_clear = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_out", 32'(out_sample), 32'h0);
    chk("rst_rdy", 32'(new_sample_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);

    // Full-scale on all voices, fixed shift 3: 0x3FFF8 >>> 3 = 0x7FFF.
    samples = {8{16'h7FFF}}; channel_en = 8'hFF; auto_gain = 1'b0;
    generate_new_sample = 1'b1;
    tick();
    generate_new_sample = 1'b0;
    chk("fs_busy_e0", 32'(busy), 32'd0);
    chk("fs_rdy_e0", 32'(new_sample_ready), 32'd0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("fs_busy_e%0d", e), 32'(busy), 32'd1);
      chk($sformatf("fs_rdy_e%0d", e), 32'(new_sample_ready), 32'd0);
    end
    tick();
    chk("fs_busy_e9", 32'(busy), 32'd0);
    chk("fs_rdy_e9", 32'(new_sample_ready), 32'd1);
    chk("fs_out", 32'(out_sample), 32'h7FFF);
    tick();
    chk("fs_rdy_e10", 32'(new_sample_ready), 32'd0);
    chk("fs_hold", 32'(out_sample), 32'h7FFF);

    // Auto gain, single voice 5: shift 0.
    p = {8{16'h1234}};
    p[5*16 +: 16] = 16'h4000;
    mix("ag1", 8'h20, 1'b1, p, 16'h4000);
    tick();

    // Auto gain, three voices at -3000: -9000 >>> 2 = -2250.
    p = {8{16'h5555}};
    p[0 +: 16] = 16'hF448; p[16 +: 16] = 16'hF448; p[32 +: 16] = 16'hF448;
    mix("ag3", 8'h07, 1'b1, p, 16'hF736);
    tick();

    // No voices enabled: zero result, normal pulse.
    mix("ag0", 8'h00, 1'b1, {8{16'h7FFF}}, 16'h0000);
    tick();

    // Inputs changed during ACCUM must not affect the mix: 8*0x1000 >>> 3.
    samples = {8{16'h1000}}; channel_en = 8'hFF; auto_gain = 1'b0;
    generate_new_sample = 1'b1;
    tick();
    generate_new_sample = 1'b0;
    tick(); tick();
    samples = {8{16'h7FFF}}; channel_en = 8'h01; auto_gain = 1'b1;
    for (int e = 3; e <= 9; e++) tick();
    chk("chg_rdy", 32'(new_sample_ready), 32'd1);
    chk("chg_out", 32'(out_sample), 32'h1000);
    tick();

    // Second request while busy is dropped and sets overrun.
    samples = {8{16'h0100}}; channel_en = 8'hFF; auto_gain = 1'b0;
    generate_new_sample = 1'b1;
    tick();
    generate_new_sample = 1'b0;
    rc = 0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 4) generate_new_sample = 1'b1;
      tick();
      generate_new_sample = 1'b0;
      if (e == 3) chk("ovr_before", 32'(overrun), 32'd0);
      if (e == 4) chk("ovr_set", 32'(overrun), 32'd1);
      if (new_sample_ready) rc++;
    end
    chk("ovr_npulse", rc, 1);
    chk("ovr_out", 32'(out_sample), 32'h0100);
    // Request in the ready cycle is accepted: (0x200+0x400) >>> 1 = 0x300.
    p = {8{16'h7000}};
    p[0 +: 16] = 16'h0200; p[16 +: 16] = 16'h0400;
    samples = p; channel_en = 8'h03; auto_gain = 1'b1;
    generate_new_sample = 1'b1;
    tick();
    generate_new_sample = 1'b0;
    chk("rc_ovr_keep", 32'(overrun), 32'd1);
    rc = 0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (new_sample_ready) rc++;
    end
    chk("rc_rdy", 32'(new_sample_ready), 32'd1);
    chk("rc_npulse", rc, 1);
    chk("rc_out", 32'(out_sample), 32'h0300);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Clear and new overrun in the same cycle: set wins.
    generate_new_sample = 1'b1;
    tick();
    clear_overrun = 1'b1;
    tick();
    generate_new_sample = 1'b0; clear_overrun = 1'b0;
    chk("ovr_setwins", 32'(overrun), 32'd1);
    for (int e = 2; e <= 10; e++) tick();

    // Reset mid-mix aborts without a pulse.
    samples = {8{16'h2000}}; channel_en = 8'hFF; auto_gain = 1'b0;
    generate_new_sample = 1'b1;
    tick();
    generate_new_sample = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    rst_n = 1'b0;
    #1;
    chk("amid_out", 32'(out_sample), 32'h0);
    chk("amid_busy", 32'(busy), 32'd0);
    chk("amid_ovr", 32'(overrun), 32'd0);
    chk("amid_rdy", 32'(new_sample_ready), 32'd0);
    rc = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (new_sample_ready) rc++;
    end
    chk("amid_nopulse", rc, 0);
    rst_n = 1'b1;
    // After release: 4*0x800 >>> 3 = 0x400 within 9 cycles.
    p = {8{16'h7FFF}};
    for (int i = 0; i < 4; i++) p[i*16 +: 16] = 16'h0800;
    mix("post_rst", 8'h0F, 1'b0, p, 16'h0400);
    tick();

    // FIXED_SHIFT=0, two full-scale voices: clamp or wrap.
    s0_samples = {8{16'h7FFF}}; s0_channel_en = 8'h03; s0_auto_gain = 1'b0;
    s0_gen = 1'b1;
    tick();
    s0_gen = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    chk("s0_rdy", 32'(s0_rdy), 32'd1);
`ifdef MIXER_SATURATE_EN
    chk("s0_out", 32'(s0_out), 32'h7FFF);
`else
    chk("s0_out", 32'(s0_out), 32'hFFFE);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised, time-multiplexed successor to the fixed 8-voice summer. It sums up to NUM_CHANNELS signed voice samples through one shared adder, one channel per clock. The sum is kept at full precision, then scaled by a fixed or auto-computed shift and saturated to the output width. It sits between the per-note sample generators and the audio DAC/codec feeder, using the same generate_new_sample / new_sample_ready handshake.

## Interface
- NUM_CHANNELS, 8, voice count; must be ≥2.
- SAMPLE_WIDTH, 16, signed sample width, input and output.
- FIXED_SHIFT, 3, right arithmetic shift applied when auto_gain=0; range 0..clog2(NUM_CHANNELS).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- samples  in  NUM_CHANNELS*SAMPLE_WIDTH  packed voices; channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- channel_en  in  NUM_CHANNELS  per-voice enable; a disabled voice contributes 0.
- auto_gain  in  1  1: shift = ceil(log2(active count)); 0: shift = FIXED_SHIFT.
- generate_new_sample  in  1  request pulse.
- clear_overrun  in  1  synchronous clear of overrun.
- out_sample  out  SAMPLE_WIDTH  signed mixed sample; registered and held between updates.
- new_sample_ready  out  1  one-cycle pulse when out_sample updates.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  sticky; a request arrived while busy.

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE: when generate_new_sample=1, capture samples, channel_en and auto_gain into internal registers. Clear the accumulator, set index=0 and active count=0, then go to ACCUM.
- ACCUM: each cycle, if the latched enable[index] is set, add the sign-extended latched sample[index] and increment the active count. After index=NUM_CHANNELS-1, go to OUTPUT.
- Accumulator width: SAMPLE_WIDTH+clog2(NUM_CHANNELS). It can never overflow.
- OUTPUT:
  - Compute shift, then acc >>> shift (arithmetic).
  - Reduce to SAMPLE_WIDTH, write out_sample, pulse new_sample_ready, return to IDLE.
- Auto gain:
  - active count 0 → out_sample=0.
  - active count 1 → shift 0.
  - 2 → 1, 3–4 → 2, 5–8 → 3, and so on.
- Requests arriving outside IDLE are dropped and set overrun. A request in the OUTPUT cycle also counts as dropped.
- clear_overrun clears overrun. If clear_overrun and a new overrun occur in the same cycle, set wins.
- Inputs that change after capture do not affect the mix in progress.

## Timing
- Request sampled at edge k; ACCUM runs from edge k+1 to edge k+NUM_CHANNELS.
- The OUTPUT update occurs at edge k+NUM_CHANNELS+1.
- new_sample_ready is high for exactly the cycle after that edge, and out_sample is valid in the same cycle. Latency is NUM_CHANNELS+1 clocks (9 at default).
- busy is high from edge k+1 until the OUTPUT edge. It is low in the cycle new_sample_ready is high, and a request in that cycle is accepted.
- Maximum accepted request rate: one per NUM_CHANNELS+1 cycles.
- Reset values: out_sample=0, new_sample_ready=0, busy=0, overrun=0, state IDLE, accumulator 0.
- Reset asserted mid-mix aborts the mix, emits no ready pulse and keeps out_sample=0.

## Configuration
- MIXER_SATURATE_EN defined: the scaled result is clamped to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
- MIXER_SATURATE_EN undefined: the scaled result is truncated to its low SAMPLE_WIDTH bits (two's-complement wrap), matching legacy behaviour.

## Structure
- Package mixer_pkg holds:
  - state enum (IDLE, ACCUM, OUTPUT);
  - helper for accumulator width (SAMPLE_WIDTH+clog2(NUM_CHANNELS));
  - function mapping active count to auto-gain shift.
- One sub-module, mixer_saturate: combinational scale-and-reduce (shift, then clamp or wrap per the macro). It is the only place MIXER_SATURATE_EN is tested.

## Test plan
- Defaults, auto_gain=0, all 8 channels enabled at 0x7FFF, request at edge 0:
  - sum 0x3FFF8 >>> 3 = 0x7FFF;
  - ready high only in the cycle after edge 9;
  - busy high edges 1–8.
- auto_gain=1, only channel 5 enabled at 0x4000 → 0x4000. Channels 0,1,2 at -3000 each → -9000>>>2 = -2250 (0xF736).
- FIXED_SHIFT=0, auto_gain=0, two channels at 0x7FFF:
  - with MIXER_SATURATE_EN → 0x7FFF;
  - without → 0xFFFE.
- channel_en=0, auto_gain=1 → out_sample=0x0000 with normal ready pulse. Changing samples during ACCUM leaves the result unchanged.
- Request at edge 0, second request at edge 4:
  - overrun=1 and only one ready pulse;
  - a request in the ready cycle is accepted;
  - clear_overrun drops overrun next cycle.
- Assert rst_n at edge 5 of a mix → outputs all zero immediately, no ready pulse. After release, a new request completes in 9 cycles.
